uart_core: RTL

Byte-wide UART peripheral on the far side of the CPU cluster's shared UART port. It accepts `uart_wr`/`uart_rd`/`uart_addr`/`uart_din` from the cluster's UART controller and returns `uart_dout`. Internally it buffers TX and RX bytes in FIFOs, serializes 8N1 frames on `txd`, and deserializes frames from `rxd`. Address 0 is the data register; address 1 is the status register.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_fifo.sv | 52 +++++
 rtl/uart_core.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register map constants, status bit indices and FSM state types for uart_core.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam logic UART_ADDR_DATA = 1'b0;
  localparam logic UART_ADDR_STAT = 1'b1;

  localparam int STAT_RX_AVAIL   = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_TX_IDLE    = 2;
  localparam int STAT_RX_OVERRUN = 3;
  localparam int STAT_FRAME_ERR  = 4;
  localparam int STAT_PARITY_ERR = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead FIFO; dout is the head entry whenever empty is low.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: register-mapped 8N1 UART with TX/RX FIFOs and sticky error flags.
// Define UART_PARITY_EN to add an even parity bit in both directions.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_din,
  input  logic       uart_wr,
  input  logic       uart_rd,
  input  logic       uart_addr,
  output logic [7:0] uart_dout,
  output logic       txd,
  input  logic       rxd
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  logic data_wr, data_rd, stat_rd;
  assign data_wr = uart_wr && (uart_addr == UART_ADDR_DATA);
  assign data_rd = uart_rd && (uart_addr == UART_ADDR_DATA);
  assign stat_rd = uart_rd && (uart_addr == UART_ADDR_STAT);

  logic [7:0] tx_head, rx_head, rx_shift_reg;
  logic       tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) tx_fifo (
    .clk(clk), .rst(rst), .push(data_wr), .pop(tx_pop), .din(uart_din),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  assign rx_pop = data_rd && !rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift_reg),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- TX ----------------
  tx_state_t     tx_state_reg, tx_state_next;
  logic [BW-1:0] tx_cnt_reg;
  logic [2:0]    tx_bit_reg;
  logic [7:0]    tx_shift_reg;
  logic          tx_tick;
`ifdef UART_PARITY_EN
  logic          tx_par_reg;
`endif

  assign tx_tick = (tx_cnt_reg == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) tx_state_reg <= TX_IDLE;
    else     tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_state_next = TX_START;
        end
      end
      TX_START: if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA: begin
        if (tx_tick && tx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
          tx_state_next = TX_PARITY;
`else
          tx_state_next = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_tick) tx_state_next = TX_STOP;
`endif
      TX_STOP: begin
        // Back-to-back frames: the next start bit follows the stop bit directly.
        if (tx_tick) begin
          if (!tx_empty) begin
            tx_pop        = 1'b1;
            tx_state_next = TX_START;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd          <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_reg   <= 1'b0;
`endif
    end else begin
      if (tx_state_reg == TX_IDLE || tx_tick) tx_cnt_reg <= '0;
      else                                    tx_cnt_reg <= tx_cnt_reg + BW'(1);
      if (tx_pop) begin
        tx_shift_reg <= tx_head;
`ifdef UART_PARITY_EN
        tx_par_reg   <= ^tx_head;
`endif
      end else if (tx_state_reg == TX_DATA && tx_tick) begin
        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
      end
      if (tx_state_reg == TX_DATA && tx_tick) tx_bit_reg <= tx_bit_reg + 3'd1;
      case (tx_state_reg)
        TX_START:  txd <= 1'b0;
        TX_DATA:   txd <= tx_shift_reg[0];
`ifdef UART_PARITY_EN
        TX_PARITY: txd <= tx_par_reg;
`endif
        default:   txd <= 1'b1;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic          rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
  rx_state_t     rx_state_reg, rx_state_next;
  logic [BW-1:0] rx_cnt_reg;
  logic [2:0]    rx_bit_reg;
  logic          rx_tick, rx_half, rx_cnt_clr;
  logic          frame_set, parity_set;

  assign rx_tick = (rx_cnt_reg == BIT_LAST);
  assign rx_half = (rx_cnt_reg == HALF_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
      rx_state_reg <= RX_IDLE;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
      rx_state_reg <= rx_state_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_clr    = rx_tick;
    rx_push       = 1'b0;
    frame_set     = 1'b0;
    parity_set    = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_clr = 1'b1;
        if (rxd_prev_reg && !rxd_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        // Mid-start sample: a line already back high was only a glitch.
        if (rx_half) begin
          rx_cnt_clr    = 1'b1;
          rx_state_next = rxd_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick && rx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
          rx_state_next = RX_PARITY;
`else
          rx_state_next = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick) begin
          parity_set    = rxd_sync_reg ^ (^rx_shift_reg);
          rx_state_next = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_tick) begin
          rx_push       = rxd_sync_reg;
          frame_set     = !rxd_sync_reg;
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      if (rx_cnt_clr) rx_cnt_reg <= '0;
      else            rx_cnt_reg <= rx_cnt_reg + BW'(1);
      if (rx_state_reg == RX_DATA && rx_tick) begin
        rx_shift_reg <= {rxd_sync_reg, rx_shift_reg[7:1]};
        rx_bit_reg   <= rx_bit_reg + 3'd1;
      end
    end
  end

  // ---------------- Flags and read data ----------------
  logic       overrun_reg, frame_err_reg, parity_err_reg;
  logic       overrun_set;
  logic [7:0] status;

  assign overrun_set = rx_push && rx_full && !rx_pop;

  always_comb begin
    status                  = '0;
    status[STAT_RX_AVAIL]   = !rx_empty;
    status[STAT_TX_FULL]    = tx_full;
    status[STAT_TX_IDLE]    = tx_empty && (tx_state_reg == TX_IDLE);
    status[STAT_RX_OVERRUN] = overrun_reg;
    status[STAT_FRAME_ERR]  = frame_err_reg;
    status[STAT_PARITY_ERR] = parity_err_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      uart_dout      <= 8'h00;
    end else begin
      overrun_reg    <= overrun_set || (overrun_reg && !stat_rd);
      frame_err_reg  <= frame_set   || (frame_err_reg && !stat_rd);
      parity_err_reg <= parity_set  || (parity_err_reg && !stat_rd);
      if (data_rd)      uart_dout <= rx_empty ? 8'h00 : rx_head;
      else if (stat_rd) uart_dout <= status;
    end
  end

endmodule
